// File: rtl/psx_pkg.sv
// Shared types and constants for the PlayStation controller host poller.
package psx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ATT_SETUP = 3'd1,
    SHIFT     = 3'd2,
    ACK_WAIT  = 3'd3,
    GAP       = 3'd4,
    FINISH    = 3'd5
  } psx_state_t;

  localparam logic [7:0] PSX_CMD_START = 8'h01;
  localparam logic [7:0] PSX_CMD_POLL  = 8'h42;
  localparam logic [7:0] PSX_CMD_IDLE  = 8'h00;

  // Command byte sent in each slot of a poll frame.
  function automatic logic [7:0] psx_tx_byte(input int unsigned idx);
    if (idx == 0) begin
      return PSX_CMD_START;
    end else if (idx == 1) begin
      return PSX_CMD_POLL;
    end else begin
      return PSX_CMD_IDLE;
    end
  endfunction

endpackage

// File: rtl/psx_host_poller_sync.sv
// Two-flop synchroniser for asynchronous controller inputs; resets to the idle-high level.
module psx_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/psx_host_poller.sv
// Host-side poller for a PlayStation controller: one frame per start request.
// Optional ack timeout enabled by defining PSX_ACK_TIMEOUT_EN.
module psx_host_poller
  import psx_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int NUM_BYTES   = 5,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   data,
  input  logic                   ack,
  output logic                   psx_clk,
  output logic                   cmd,
  output logic                   att,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout_err,
  output logic [8*NUM_BYTES-1:0] rx_data
);

  localparam int DIV_W  = $clog2(2 * CLK_DIV);
  localparam int BYTE_W = $clog2(NUM_BYTES);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_RISE  = DIV_W'(CLK_DIV);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

  if (CLK_DIV < 2 || NUM_BYTES < 3 || NUM_BYTES > 9 || ACK_TIMEOUT < 1) begin : g_param_check
    $error("psx_host_poller: parameter out of range");
  end

  psx_state_t state, state_nxt;

  logic [DIV_W-1:0]       div_cnt;
  logic [2:0]             bit_cnt;
  logic [BYTE_W-1:0]      byte_cnt;
  logic [7:0]             shreg;
  logic [8*NUM_BYTES-1:0] hold;
  logic [7:0]             tx_byte;
  logic                   data_s, ack_s;
  logic                   div_wrap, bit_end, byte_end, last_byte, to_hit;

  psx_sync2 u_sync_data (.clk(clk), .rst_n(rst_n), .d(data), .q(data_s));
  psx_sync2 u_sync_ack  (.clk(clk), .rst_n(rst_n), .d(ack),  .q(ack_s));

  assign div_wrap  = (div_cnt == DIV_LAST);
  assign bit_end   = (state == SHIFT) && div_wrap;
  assign byte_end  = bit_end && (bit_cnt == 3'd7);
  assign last_byte = (byte_cnt == BYTE_LAST);
  assign tx_byte   = psx_tx_byte(32'(byte_cnt));

`ifdef PSX_ACK_TIMEOUT_EN
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;

  // Counts cycles spent waiting; an ack in the same cycle takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == ACK_WAIT) begin
      to_cnt <= to_cnt + TO_W'(1);
    end else begin
      to_cnt <= '0;
    end
  end

  assign to_hit = (state == ACK_WAIT) && ack_s && (to_cnt == TO_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= to_hit;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = ATT_SETUP;
      ATT_SETUP: if (div_wrap) state_nxt = SHIFT;
      SHIFT:     if (byte_end) state_nxt = last_byte ? FINISH : ACK_WAIT;
      ACK_WAIT: begin
        if (!ack_s) begin
          state_nxt = GAP;
        end else if (to_hit) begin
          state_nxt = IDLE;
        end
      end
      GAP:       if (div_wrap) state_nxt = SHIFT;
      FINISH:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    att     = 1'b1;
    busy    = 1'b0;
    done    = 1'b0;
    psx_clk = 1'b1;
    cmd     = 1'b1;
    case (state)
      ATT_SETUP, ACK_WAIT, GAP: begin
        att  = 1'b0;
        busy = 1'b1;
      end
      SHIFT: begin
        att     = 1'b0;
        busy    = 1'b1;
        psx_clk = (div_cnt >= DIV_RISE);
        cmd     = tx_byte[bit_cnt];
      end
      FINISH:  done = 1'b1;
      default: ;
    endcase
  end

  // Divider runs only in timed states and always restarts from zero on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
    end else begin
      if (state == ATT_SETUP || state == SHIFT || state == GAP) begin
        div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
      end else begin
        div_cnt <= '0;
      end
      if (state == IDLE) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else begin
        if (bit_end) bit_cnt <= bit_cnt + 3'd1;
        if (byte_end && !last_byte) byte_cnt <= byte_cnt + BYTE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == SHIFT && div_cnt == DIV_RISE) begin
      shreg <= {data_s, shreg[7:1]};
    end
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (byte_end && byte_cnt == BYTE_W'(i)) hold[8*i +: 8] <= shreg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data <= '0;
    end else if (state == FINISH) begin
      rx_data <= hold;
    end
  end

endmodule
